// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;

  // Frame FSM states
  typedef enum logic [1:0] {
    IDLE,
    LEN,
    DATA,
    DONE
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam logic [7:0]  DEFAULT_SYNC   = 8'hA5;

endpackage

// File: rtl/imem_loader_if.sv
// Instruction-memory write port driven by the boot loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 7
) ();

  logic              we0;
  logic [31:0]       wr_din0;
  logic [ADDR_W-1:0] wr_addr0;

  modport master (output we0, output wr_din0, output wr_addr0);
  modport slave  (input  we0, input  wr_din0, input  wr_addr0);

endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle byte/error pulses.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;

  rx_state_t        st_q, st_d;
  logic             sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic             valid_q, valid_d, ferr_q, ferr_d;
  logic [7:0]       data_q, data_d;

  // Next-state: start-edge detect, half-bit confirm, then sample once per bit period
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    sync1_d = rx;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    case (st_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          st_d  = RX_START;
          cnt_d = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = sync2_q ? RX_IDLE : RX_BITS;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_BITS: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          sh_d  = {sync2_q, sh_q[7:1]};
          if (bit_q == 3'd7) st_d = RX_STOP;
          else bit_d = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == LAST) begin
          st_d = RX_IDLE;
          if (sync2_q) begin
            valid_d = 1'b1;
            data_d  = sh_q;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: st_d = RX_IDLE;
    endcase
  end

  // State register; synchroniser idles high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= RX_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign byte_valid = valid_q;
  assign byte_data  = data_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: framed UART image -> sequential 32-bit instruction-memory writes.
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned ADDR_W       = 7,
  parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  imem_loader_if.master wr,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          load_err
);

  localparam int unsigned CW  = ADDR_W + 1;
  localparam int unsigned CAP = 1 << ADDR_W;
  localparam logic [1:0]  LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic       byte_valid, frame_err;
  logic [7:0] byte_data;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d, wcount_q, wcount_d;
  logic [31:0]       word_q, word_d, din_q, din_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              we0_q, we0_d, hold_q, hold_d, busy_q, busy_d;
  logic              done_q, done_d, err_q, err_d;

  // Frame FSM, word assembler and address counter
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    wcount_d = wcount_q;
    word_d   = word_q;
    din_d    = din_q;
    waddr_d  = waddr_q;
    hold_d   = hold_q;
    err_d    = err_q;
    we0_d    = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (byte_valid && byte_data == SYNC_BYTE) begin
          state_d = LEN;
          hold_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
      LEN: begin
        if (frame_err) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (byte_valid) begin
          // zero or oversize counts clamp to full capacity so the address never wraps
          if (byte_data == 8'd0 || 32'(byte_data) > CAP) wcount_d = CW'(CAP);
          else wcount_d = CW'(byte_data);
          idx_d   = '0;
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (frame_err) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (byte_valid) begin
          word_d[{idx_q, 3'b000} +: 8] = byte_data;
          if (idx_q == LAST_IDX) begin
            we0_d   = 1'b1;
            din_d   = {byte_data, word_q[23:0]};
            waddr_d = cnt_q[ADDR_W-1:0];
            cnt_d   = cnt_q + CW'(1);
            idx_d   = '0;
            if (cnt_q + CW'(1) == wcount_q) state_d = DONE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        hold_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == LEN) || (state_d == DATA);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      wcount_q <= '0;
      word_q   <= '0;
      din_q    <= '0;
      waddr_q  <= '0;
      we0_q    <= 1'b0;
      hold_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      wcount_q <= wcount_d;
      word_q   <= word_d;
      din_q    <= din_d;
      waddr_q  <= waddr_d;
      we0_q    <= we0_d;
      hold_q   <= hold_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign wr.we0      = we0_q;
  assign wr.wr_din0  = din_q;
  assign wr.wr_addr0 = waddr_q;
  assign cpu_hold    = hold_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign load_err    = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame-level write model plus per-cycle bus checks.
module tb_imem_loader;

  localparam int unsigned CPB = 4;
  localparam int unsigned AW  = 7;
  localparam int unsigned CAP = 1 << AW;
  localparam logic [7:0]  SYNC = 8'hA5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;
  logic cpu_hold, busy, done, load_err;

  imem_loader_if #(.ADDR_W(AW)) wr ();

  imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .SYNC_BYTE(SYNC)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .wr       (wr),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         log_q[$];
  logic [31:0] tx_words[$];
  wr_t         cur;
  int          n_chk = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  int          exp_done = 0;
  int          bv_cnt = 0;
  logic [31:0] last_din;
  logic [AW-1:0] last_addr;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endfunction

  // Per-cycle write-port check against the expected-write queue
  always @(negedge clk) begin
    if (reset) begin
      last_din  = '0;
      last_addr = '0;
    end else begin
      if (wr.we0) begin
        log_q.push_back({wr.wr_addr0, wr.wr_din0});
        chk("hold_during_write", 32'(cpu_hold), 32'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_we0", 32'(wr.wr_addr0), 32'hFFFF_FFFF);
        end else begin
          cur = exp_q.pop_front();
          chk("wr_addr0", 32'(wr.wr_addr0), 32'(cur.addr));
          chk("wr_din0", wr.wr_din0, cur.data);
        end
        last_din  = wr.wr_din0;
        last_addr = wr.wr_addr0;
      end else begin
        if (wr.wr_din0 !== last_din || wr.wr_addr0 !== last_addr)
          chk("bus_hold_idle", wr.wr_din0, last_din);
      end
      if (done) begin
        done_cnt++;
        chk("done_with_pending", 32'(exp_q.size()), 32'd0);
      end
    end
  end

  // Receiver pulse counter, used for the glitch check
  always @(negedge clk) begin
    if (!reset && dut.u_rx.byte_valid) bv_cnt++;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat ($urandom_range(0, CPB)) @(negedge clk);
  endtask

  // Sends a complete frame; word count comes from the length rule (0 or >CAP -> CAP)
  task automatic send_load(input logic [7:0] n_byte, input logic skip_sync);
    int nw;
    logic [31:0] word;
    nw = (n_byte == 8'd0 || 32'(n_byte) > CAP) ? int'(CAP) : int'(n_byte);
    if (!skip_sync) send_byte(SYNC, 1'b1);
    send_byte(n_byte, 1'b1);
    for (int w = 0; w < nw; w++) begin
      word = (tx_words.size() > 0) ? tx_words.pop_front() : $urandom;
      for (int k = 0; k < 4; k++) begin
        if (k == 3) exp_q.push_back({AW'(w), word});
        send_byte(word[8*k +: 8], 1'b1);
      end
    end
    exp_done++;
  endtask

  task automatic settle_check();
    repeat (4 * CPB) @(negedge clk);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    chk("busy_after_load", 32'(busy), 32'd0);
    chk("hold_after_load", 32'(cpu_hold), 32'd0);
    chk("err_after_load", 32'(load_err), 32'd0);
    chk("done_count", 32'(done_cnt), 32'(exp_done));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_we0"}, 32'(wr.we0), 32'd0);
    chk({tag, "_din"}, wr.wr_din0, 32'd0);
    chk({tag, "_addr"}, 32'(wr.wr_addr0), 32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(load_err), 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    int bv0;

    // reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // two-word frame with known contents
    log_q.delete();
    tx_words.push_back(32'h12345678);
    tx_words.push_back(32'hDEADBEEF);
    send_load(8'h02, 1'b0);
    settle_check();
    chk("pin_nwrites", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      chk("pin_w0_data", log_q[0].data, 32'h12345678);
      chk("pin_w0_addr", 32'(log_q[0].addr), 32'd0);
      chk("pin_w1_data", log_q[1].data, 32'hDEADBEEF);
      chk("pin_w1_addr", 32'(log_q[1].addr), 32'd1);
    end

    // non-sync bytes before a frame are ignored
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    repeat (4 * CPB) @(negedge clk);
    chk("pre_hold", 32'(cpu_hold), 32'd0);
    chk("pre_busy", 32'(busy), 32'd0);
    send_byte(SYNC, 1'b1);
    repeat (4 * CPB) @(negedge clk);
    chk("len_busy", 32'(busy), 32'd1);
    chk("len_hold", 32'(cpu_hold), 32'd1);
    send_load(8'h01, 1'b1);
    settle_check();

    // N = 0 means full capacity
    log_q.delete();
    send_load(8'h00, 1'b0);
    settle_check();
    chk("cap0_nwrites", 32'(log_q.size()), 32'(CAP));
    if (log_q.size() == CAP) chk("cap0_last_addr", 32'(log_q[CAP-1].addr), 32'd127);

    // oversize N clamps to capacity
    log_q.delete();
    send_load(8'hC8, 1'b0);
    settle_check();
    chk("clamp_nwrites", 32'(log_q.size()), 32'(CAP));

    // frame error mid-word aborts the load
    log_q.delete();
    send_byte(SYNC, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    repeat (4 * CPB) @(negedge clk);
    chk("abort_err", 32'(load_err), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hold", 32'(cpu_hold), 32'd1);
    chk("abort_nwrites", 32'(log_q.size()), 32'd0);
    send_load(8'h01, 1'b0);
    settle_check();

    // reset in the middle of the 3rd byte of the second word
    send_byte(SYNC, 1'b1);
    send_byte(8'h02, 1'b1);
    begin
      logic [31:0] w0;
      w0 = $urandom;
      for (int k = 0; k < 4; k++) begin
        if (k == 3) exp_q.push_back({AW'(0), w0});
        send_byte(w0[8*k +: 8], 1'b1);
      end
    end
    send_byte(8'h5C, 1'b1);
    send_byte(8'hC3, 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = 1'($urandom_range(0, 1));
      repeat (CPB) @(negedge clk);
    end
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    chk("midreset_pending", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    rx = 1'b1;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    send_load(8'h02, 1'b0);
    settle_check();

    // one-cycle low glitch in idle is rejected
    bv0 = bv_cnt;
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (20 * CPB) @(negedge clk);
    chk("glitch_bytes", 32'(bv_cnt), 32'(bv0));
    chk("glitch_busy", 32'(busy), 32'd0);
    chk("glitch_hold", 32'(cpu_hold), 32'd0);

    // randomized frames with leading noise bytes
    for (int it = 0; it < 6; it++) begin
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        b = 8'($urandom_range(0, 255));
        if (b == SYNC) b = 8'h5A;
        send_byte(b, 1'b1);
      end
      send_load(8'($urandom_range(1, 6)), 1'b0);
      settle_check();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Serial boot loader that sits directly upstream of the instruction memory write port (we0 / wr_din0 / wr_addr0) of the single-cycle core's control unit.
- Receives a framed program image over 8N1 UART and assembles 32-bit little-endian words.
- Writes each word into instruction memory sequentially from word 0.
- Holds the core in reset (cpu_hold) for the whole load, so a partial image never executes.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); minimum 4.
- ADDR_W, 7, instruction-memory word-address width; capacity 2**ADDR_W words.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx  in  1  UART serial input; idle high; asynchronous to clk
- we0  out  1  instruction-memory write enable; one-cycle pulse per word
- wr_din0  out  32  word to write
- wr_addr0  out  ADDR_W  word address to write
- cpu_hold  out  1  high while loading or after an aborted load; OR'd into the core's reset
- busy  out  1  high in states LEN and DATA
- done  out  1  one-cycle pulse when a load completes
- load_err  out  1  sticky frame-error flag

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (ports clk, reset). All outputs are 0 on reset: we0, wr_din0, wr_addr0, cpu_hold, busy, done, load_err. The rx synchroniser flops reset to 1. FSM resets to IDLE.
- rx synchronisation: 2-flop synchroniser.
- Start-bit detection: a start bit is a synchronised falling edge. It is confirmed low at half a bit (CLKS_PER_BIT/2); if high there, it is a glitch and the receiver returns to idle.
- Bit sampling: data bits are sampled every CLKS_PER_BIT thereafter, LSB first.
- Stop bit: sampled 1 gives byte_valid, a one-cycle pulse with byte_data. Sampled 0 gives frame_err, a one-cycle pulse with no byte_valid.
- FSM state IDLE:
  - byte == SYNC_BYTE: go to LEN; cpu_hold <= 1; load_err <= 0.
  - Any other byte, or frame_err: ignored.
- FSM state LEN:
  - Next byte N sets word count = N; N == 0 means 2**ADDR_W words.
  - N > 2**ADDR_W is clamped to 2**ADDR_W.
  - Reset byte index and address counter to 0, then go to DATA.
- FSM state DATA:
  - Byte k of the current word (k = 0..3) is placed into bits [8k+7:8k].
  - On the cycle after byte 3's byte_valid: we0 = 1, wr_din0 = assembled word, wr_addr0 = address counter.
  - The address counter and written-word count then increment.
  - When written count == word count, go to DONE.
- FSM state DONE (1 cycle): done = 1, cpu_hold <= 0, then go to IDLE.
- we0 timing:
  - Latency is exactly one clk from the 4th byte_valid to we0.
  - wr_din0 / wr_addr0 hold their last values when we0 = 0.
  - The address never wraps, because the count is clamped.
- frame_err in LEN or DATA:
  - Abort to IDLE; load_err <= 1 (sticky); no further we0.
  - cpu_hold stays 1 until a later load completes; partially written words are left as-is.
- SYNC_BYTE arriving inside LEN or DATA is treated as data, not a restart.
- Simultaneous events: byte_valid and frame_err never coincide. A done pulse and a new start bit may overlap; the receiver keeps running independently of the FSM.
- Reset mid-load: returns immediately to reset values; cpu_hold drops to 0 (core runs its init image).
- busy = 1 in LEN and DATA only.

Decomposition:
- Shared package loader_pkg holds:
  - state enum {IDLE, LEN, DATA, DONE}
  - BYTES_PER_WORD = 4
  - default SYNC_BYTE
- One sub-module, uart_rx, contains:
  - the synchroniser and bit-timing counter
  - the shift register
  - byte_valid / byte_data / frame_err outputs
- imem_loader holds the frame FSM, word assembler and address counter.

Test Plan (CLKS_PER_BIT = 4, ADDR_W = 7):
- Send A5, 02, 78 56 34 12, EF BE AD DE:
  - we0 pulses twice: addr 0 = 0x12345678, addr 1 = 0xDEADBEEF.
  - done pulses once after the 2nd write.
  - cpu_hold 1 from A5 until the done cycle, then 0.
- Send 00, 11, A5 before a valid frame: no we0 and cpu_hold stays 0 until A5 is received; then LEN is entered.
- Send A5, 00, then 512 bytes: 128 writes at addr 0..127, and wr_addr0 never exceeds 127. Also send A5, C8: clamped, exactly 128 writes, then done.
- Send A5, 01, two data bytes, then a byte with stop bit 0:
  - load_err = 1, FSM in IDLE, no we0, cpu_hold stays 1.
  - A following good A5, 01 frame clears load_err, writes addr 0, and drops cpu_hold.
- Assert reset midway through the 3rd byte of a word: all outputs 0 immediately. A complete frame after reset loads correctly, showing no stale byte index.
- A 1-clk low glitch on rx in IDLE produces no byte_valid and no state change.
